// File: rtl/mem_pkg.sv
// Shared encodings and constants for the data-memory stage.
// Size and extension codes match the mem_mask / sel_memdata pins.
package mem_pkg;

    typedef enum logic [3:0] {
        SZ_B = 4'b0001,
        SZ_H = 4'b0010,
        SZ_W = 4'b0100,
        SZ_D = 4'b1000
    } mem_size_e;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01
    } mem_ext_e;

    localparam logic [63:0] DEF_BASE_ADDR     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEF_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    // Zero means the mask is not a legal one-hot size.
    function automatic logic [3:0] mask_bytes(input logic [3:0] mask);
        logic [3:0] n;
        case (mask)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Lane extract plus sign/zero extension, shared by the RAM and mtimecmp read paths.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  lane,
    input  logic [3:0]  mem_mask,
    input  logic [1:0]  sel_memdata,
    output logic [63:0] data
);

    logic [63:0] shifted;
    logic        sign_ext;

    always_comb begin
        shifted  = word >> {lane, 3'b000};
        sign_ext = (sel_memdata == EXT_SIGN);
        data     = '0;
        if (sel_memdata == EXT_SIGN || sel_memdata == EXT_ZERO) begin
            case (mem_mask)
                SZ_B:    data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
                SZ_H:    data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
                SZ_W:    data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
                SZ_D:    data = shifted;
                default: data = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Data-memory stage: 64-bit RAM with combinational read / synchronous write, plus mtimecmp MMIO redirect.
// Optional macro MEM_ACCESS_ERR_EN adds the acc_err output.
module mem_stage_unit
    import mem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          DEPTH         = 4096,
    parameter logic [63:0] MTIMECMP_ADDR = DEF_MTIMECMP_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wen,
    input  logic [3:0]  mem_mask,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [1:0]  sel_memdata,
    input  logic [63:0] mtcmp_rdata,
`ifdef MEM_ACCESS_ERR_EN
    output logic        acc_err,
`endif
    output logic [63:0] rdata,
    output logic        mtcmp_we,
    output logic        mtcmp_re,
    output logic [63:0] mtcmp_wdata
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH) * 64'd8;

    logic [63:0]      mem [DEPTH];

    logic [3:0]       nbytes;
    logic             legal;
    logic             active;
    logic             mmio_hit;
    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             ram_we;
    logic             rd_hit;
    logic [7:0]       size_en;
    logic [7:0]       byte_en;
    logic [63:0]      wdata_shift;
    logic [63:0]      rd_word;
    logic [63:0]      ext_data;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    always_comb begin
        nbytes   = mask_bytes(mem_mask);
        legal    = (nbytes != 4'd0);
        active   = ena && !rst && legal;
        mmio_hit = (addr == MTIMECMP_ADDR);
        offset   = addr - BASE_ADDR;
        in_range = (offset < RAM_BYTES);
        word_idx = offset[IDX_W+2:3];
        ram_we   = active && wen && !mmio_hit && in_range;
        rd_hit   = active && !wen && (mmio_hit || in_range);
    end

    always_comb begin
        case (mem_mask)
            SZ_B:    size_en = 8'h01;
            SZ_H:    size_en = 8'h03;
            SZ_W:    size_en = 8'h0F;
            SZ_D:    size_en = 8'hFF;
            default: size_en = 8'h00;
        endcase
        // Lanes pushed past bit 7 fall off, dropping bytes that would cross the doubleword.
        byte_en     = size_en << addr[2:0];
        wdata_shift = wdata << {addr[2:0], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_shift[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mmio_hit ? mtcmp_rdata : mem[word_idx];

    mem_load_ext u_load_ext (
        .word        (rd_word),
        .lane        (addr[2:0]),
        .mem_mask    (mem_mask),
        .sel_memdata (sel_memdata),
        .data        (ext_data)
    );

    always_comb begin
        rdata       = rd_hit ? ext_data : 64'd0;
        mtcmp_we    = active && wen && mmio_hit;
        mtcmp_re    = active && !wen && mmio_hit;
        mtcmp_wdata = mtcmp_we ? wdata : 64'd0;
    end

`ifdef MEM_ACCESS_ERR_EN
    logic [2:0] align_mask;

    always_comb begin
        align_mask = 3'(nbytes - 4'd1);
        acc_err    = ena && !rst &&
                     (!legal ||
                      ((addr[2:0] & align_mask) != 3'd0) ||
                      (!in_range && !mmio_hit));
    end
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed vector table followed by randomized traffic
// checked against a byte-array reference model.
module tb_mem_stage_unit;

    localparam logic [63:0] BASE     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MTCMP    = 64'h0000_0000_0200_4000;
    localparam logic [63:0] WIN_BASE = BASE + 64'h100;
    localparam int          WIN_WORDS = 16;
    localparam int          DEPTH    = 4096;

    logic        clk = 1'b0;
    logic        rst, ena, wen;
    logic [3:0]  mem_mask;
    logic [63:0] addr, wdata, mtcmp_rdata;
    logic [1:0]  sel_memdata;
    logic [63:0] rdata, mtcmp_wdata;
    logic        mtcmp_we, mtcmp_re;
`ifdef MEM_ACCESS_ERR_EN
    logic        acc_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst, ena, wen;
        logic [3:0]  mask;
        logic [63:0] addr, wdata;
        logic [1:0]  sel;
        logic [63:0] mtin;
        logic [63:0] exp_rd;
        logic        exp_we, exp_re;
        logic [63:0] exp_wd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model_mem [WIN_WORDS*8];

    always #5 clk = ~clk;

    mem_stage_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .wen         (wen),
        .mem_mask    (mem_mask),
        .addr        (addr),
        .wdata       (wdata),
        .sel_memdata (sel_memdata),
        .mtcmp_rdata (mtcmp_rdata),
`ifdef MEM_ACCESS_ERR_EN
        .acc_err     (acc_err),
`endif
        .rdata       (rdata),
        .mtcmp_we    (mtcmp_we),
        .mtcmp_re    (mtcmp_re),
        .mtcmp_wdata (mtcmp_wdata)
    );

    function automatic logic [3:0] size_to_mask(input int size);
        case (size)
            1:       return 4'b0001;
            2:       return 4'b0010;
            4:       return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [63:0] extend_val(input logic [63:0] raw, input int size, input int sel);
        logic [63:0] keep, v;
        if (sel >= 2) return 64'd0;
        if (size == 8) return raw;
        keep = (64'd1 << (8*size)) - 64'd1;
        v = raw & keep;
        if (sel == 0 && v[8*size-1]) v = v | ~keep;
        return v;
    endfunction

    task automatic addVec(input logic r, input logic e, input logic w, input logic [3:0] m,
                          input logic [63:0] a, input logic [63:0] wd, input logic [1:0] s,
                          input logic [63:0] mt, input logic [63:0] erd, input logic ewe,
                          input logic ere, input logic [63:0] ewd, input logic eerr);
        vec_t v;
        v.rst = r; v.ena = e; v.wen = w; v.mask = m; v.addr = a; v.wdata = wd;
        v.sel = s; v.mtin = mt; v.exp_rd = erd; v.exp_we = ewe; v.exp_re = ere;
        v.exp_wd = ewd; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; ena = v.ena; wen = v.wen; mem_mask = v.mask; addr = v.addr;
        wdata = v.wdata; sel_memdata = v.sel; mtcmp_rdata = v.mtin;
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [63:0] act,
                               input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input string tag, input int idx);
        applyStimulus(v);
        checkOutput({tag, " rdata"}, idx, rdata, v.exp_rd);
        checkOutput({tag, " mtcmp_we"}, idx, 64'(mtcmp_we), 64'(v.exp_we));
        checkOutput({tag, " mtcmp_re"}, idx, 64'(mtcmp_re), 64'(v.exp_re));
        checkOutput({tag, " mtcmp_wdata"}, idx, mtcmp_wdata, v.exp_wd);
`ifdef MEM_ACCESS_ERR_EN
        checkOutput({tag, " acc_err"}, idx, 64'(acc_err), 64'(v.exp_err));
`endif
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; wen = 1'b0; mem_mask = 4'b0; addr = '0;
        wdata = '0; sel_memdata = 2'b0; mtcmp_rdata = '0;

        // rst ena wen mask addr wdata sel mtin | rdata we re wdata err
        addVec(1,0,0,4'b1000, BASE+8, 64'h0, 0, 64'h0, 64'h0, 0,0, 64'h0, 0);
        addVec(0,1,1,4'b1000, 64'h8000_0008, 64'h1122334455667788, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 0, 0, 64'h1122334455667788, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 1, 0, 64'h1122334455667788, 0,0, 0, 0);
        addVec(0,1,1,4'b1000, 64'h8000_0000, 0, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,1,4'b0001, 64'h8000_0003, 64'h80, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b0001, 64'h8000_0003, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, 0,0, 0, 0);
        addVec(0,1,0,4'b0001, 64'h8000_0003, 0, 1, 0, 64'h80, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0000, 0, 0, 0, 64'h0000000080000000, 0,0, 0, 0);
        addVec(0,1,1,4'b0100, 64'h8000_0004, 64'hDEADBEEF, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b0100, 64'h8000_0004, 0, 0, 0, 64'hFFFFFFFFDEADBEEF, 0,0, 0, 0);
        addVec(0,1,0,4'b0010, 64'h8000_0006, 0, 1, 0, 64'hDEAD, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0000, 0, 0, 0, 64'hDEADBEEF80000000, 0,0, 0, 0);
        addVec(0,1,1,4'b1000, MTCMP, 64'h1234, 0, 0, 0, 1,0, 64'h1234, 0);
        addVec(0,1,0,4'b1000, MTCMP, 0, 0, 64'h55, 64'h55, 0,1, 0, 0);
        addVec(0,1,0,4'b0001, MTCMP, 0, 0, 64'hF0, 64'hFFFFFFFFFFFFFFF0, 0,1, 0, 0);
        addVec(1,1,1,4'b1000, 64'h8000_0008, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 0,0, 0, 0);
        addVec(1,1,0,4'b1000, 64'h8000_0008, 0, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,1,4'b0001, 64'h8000_0010, 64'h5A, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b0001, 64'h8000_0010, 0, 1, 0, 64'h5A, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 0, 0, 64'h1122334455667788, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h0000_1000, 0, 0, 0, 0, 0,0, 0, 1);
        addVec(0,1,1,4'b1000, 64'h0000_1000, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0,0, 0, 1);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 2, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b0011, 64'h8000_0008, 0, 0, 0, 0, 0,0, 0, 1);
        addVec(0,0,1,4'b1000, 64'h8000_0008, 64'h0, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 0, 0, 64'h1122334455667788, 0,0, 0, 0);
        addVec(0,1,1,4'b1000, 64'h8000_7FF8, 64'hCAFEF00D12345678, 0, 0, 0, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_7FF8, 0, 0, 0, 64'hCAFEF00D12345678, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_8000, 0, 0, 0, 0, 0,0, 0, 1);
        addVec(0,1,1,4'b0010, 64'h8000_0007, 64'hBBAA, 0, 0, 0, 0,0, 0, 1);
        addVec(0,1,0,4'b1000, 64'h8000_0000, 0, 0, 0, 64'hAAADBEEF80000000, 0,0, 0, 0);
        addVec(0,1,0,4'b1000, 64'h8000_0008, 0, 0, 0, 64'h1122334455667788, 0,0, 0, 0);
        addVec(0,1,1,4'b0011, MTCMP, 64'h99, 0, 0, 0, 0,0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], "dir", i);

        // Seed the random window so every model byte is known.
        for (int w = 0; w < WIN_WORDS; w++) begin
            vec_t v;
            logic [63:0] d;
            d = {$urandom, $urandom};
            v = '{1'b0, 1'b1, 1'b1, 4'b1000, WIN_BASE + 64'(8*w), d, 2'b0, 64'h0,
                  64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
            runVec(v, "init", w);
            for (int k = 0; k < 8; k++) model_mem[8*w+k] = d[8*k +: 8];
        end

        for (int n = 0; n < 400; n++) begin
            vec_t v;
            int kind, size, lane, w, sel;
            logic [63:0] raw;
            kind = $urandom_range(0, 15);
            size = 1 << $urandom_range(0, 3);
            w    = $urandom_range(0, WIN_WORDS-1);
            sel  = $urandom_range(0, 3);
            v = '{1'b0, 1'b1, 1'b0, size_to_mask(size), 64'h0, {$urandom, $urandom}, 2'(sel),
                  {$urandom, $urandom}, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
            if (kind < 6) begin
                lane = $urandom_range(0, 7);
                v.wen = 1'b1;
                v.addr = WIN_BASE + 64'(8*w + lane);
                v.exp_err = (lane % size) != 0;
                runVec(v, "rnd_wr", n);
                for (int k = 0; k < size; k++)
                    if (lane + k < 8) model_mem[8*w+lane+k] = v.wdata[8*k +: 8];
            end else if (kind < 12) begin
                lane = size * $urandom_range(0, 8/size - 1);
                v.addr = WIN_BASE + 64'(8*w + lane);
                raw = '0;
                for (int k = 0; k < size; k++) raw[8*k +: 8] = model_mem[8*w+lane+k];
                v.exp_rd = extend_val(raw, size, sel);
                runVec(v, "rnd_rd", n);
            end else if (kind == 12) begin
                v.addr = MTCMP;
                v.wen = 1'($urandom_range(0, 1));
                v.exp_we = v.wen;
                v.exp_re = !v.wen;
                v.exp_wd = v.wen ? v.wdata : 64'h0;
                v.exp_rd = v.wen ? 64'h0 : extend_val(v.mtin, size, sel);
                runVec(v, "rnd_mmio", n);
            end else if (kind == 13) begin
                v.wen = 1'($urandom_range(0, 1));
                v.addr = ($urandom_range(0, 1) == 0) ? BASE - 64'h8
                                                     : BASE + 64'(8*DEPTH) + 64'(8*w);
                v.exp_err = 1'b1;
                runVec(v, "rnd_oor", n);
            end else if (kind == 14) begin
                v.ena = 1'b0;
                v.wen = 1'($urandom_range(0, 1));
                v.addr = WIN_BASE + 64'(8*w);
                runVec(v, "rnd_idle", n);
            end else begin
                v.mask = 4'b0110;
                v.wen = 1'($urandom_range(0, 1));
                v.addr = WIN_BASE + 64'(8*w);
                v.exp_err = 1'b1;
                runVec(v, "rnd_badmask", n);
            end
        end

        // Confirm the whole window still matches after the random traffic.
        for (int w = 0; w < WIN_WORDS; w++) begin
            vec_t v;
            logic [63:0] raw;
            for (int k = 0; k < 8; k++) raw[8*k +: 8] = model_mem[8*w+k];
            v = '{1'b0, 1'b1, 1'b0, 4'b1000, WIN_BASE + 64'(8*w), 64'h0, 2'b0, 64'h0,
                  raw, 1'b0, 1'b0, 64'h0, 1'b0};
            runVec(v, "final", w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
